serial_adder: RTL
=================

// Module: serial_adder
// PURPOSE
//  Bit-serial WIDTH-bit adder wrapped around a single full-adder cell plus a carry flop.
//  Accepts two parallel operands and a carry-in over a valid/ready handshake.
//  Adds one bit per clock, LSB first, and presents the parallel sum and carry-out over a
//  second valid/ready handshake.
//  Sits directly upstream of the full-adder cell: it feeds the cell's a/b/c inputs each
//  cycle and consumes its sum/carry outputs. Trades area for WIDTH cycles of latency.
// PARAMETERS
//  WIDTH   8   operand/sum width in bits, >= 2
// PORTS
//  clk        in   1      single clock, all state updates on rising edge
//  rst_n      in   1      synchronous, active-low reset
//  in_valid   in   1      operands a/b/cin valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  operand A (unsigned; two's-complement for ovf)
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in
//  out_valid  out  1      sum/cout valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  a+b+cin modulo 2^WIDTH
//  cout       out  1      carry-out of bit WIDTH-1
//  ovf        out  1      signed overflow (only with SERIAL_ADDER_OVF_EN)
// BEHAVIOUR
//  - Reset (rst_n=0 at an edge): state=IDLE; in_ready=1; out_valid=0; sum=0; cout=0; ovf=0;
//    bit counter=0; operand regs=0. Reset mid-operation discards the operation; no output.
//  - FSM states: IDLE, SHIFT, DONE.
//  - IDLE:
//    - in_ready=1.
//    - On in_valid&&in_ready: load A_sr=a, B_sr=b, carry=cin, cnt=0; go to SHIFT.
//  - SHIFT:
//    - in_ready=0; in_valid is ignored.
//    - Each edge: the FA cell takes (A_sr[0], B_sr[0], carry).
//    - Its sum bit enters sum shift reg at MSB (shift right); carry <= cell carry.
//    - A_sr and B_sr shift right; cnt++.
//    - At the edge where cnt==WIDTH-1: go to DONE, cout <= cell carry.
//  - DONE:
//    - out_valid=1; sum/cout/ovf held stable until handshake.
//    - On out_ready: go to IDLE; out_valid drops next cycle.
//  - Latency: acceptance edge T, out_valid high after edge T+WIDTH.
//  - Throughput: with out_ready held high, one result per WIDTH+2 cycles.
//  - sum/cout are only meaningful while out_valid=1; sum reg contents during SHIFT are partial.
//  - cnt width: $clog2(WIDTH); no wrap beyond WIDTH-1 (reset to 0 on load).
//  - Backpressure: out_ready=0 in DONE holds state indefinitely; in_ready stays 0.
// CONFIGURATION
//  - SERIAL_ADDER_OVF_EN defined:
//    - Port ovf exists.
//    - At the final SHIFT edge, ovf <= carry_into_msb ^ cell_carry_out.
//    - ovf is held with sum; cleared to 0 on reset.
//  - Undefined: ovf port and its logic are absent; all other behaviour is identical.
// STRUCTURE
//  - Package serial_adder_pkg:
//    - state typedef (IDLE/SHIFT/DONE, 2-bit encoding);
//    - WIDTH_DEFAULT=8;
//    - cnt-width helper.
//  - One sub-module fa_cell: purely combinational full adder.
//    - sum=a^b^c, carry=majority(a,b,c).
//    - Instantiated once.
//  - Top holds FSM, counter, shift regs, carry flop.
// TESTING
//  1. WIDTH=8, a=0x0F b=0x01 cin=0 -> out_valid 8 cycles after accept; sum=0x10, cout=0.
//  2. a=0xFF b=0x01 cin=0 -> sum=0x00, cout=1, ovf=0.
//     a=0x00 b=0x00 cin=1 -> sum=0x01, cout=0.
//  3. OVF_EN: a=0x7F b=0x01 cin=0 -> sum=0x80, cout=0, ovf=1.
//     a=0x80 b=0x80 -> sum=0x00, cout=1, ovf=1.
//  4. Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum/cout stable, in_ready=0.
//     Then release -> IDLE, in_ready=1 next cycle.
//  5. Pulse in_valid with new operands during SHIFT -> ignored; result equals first operands.
//  6. Assert rst_n=0 at cycle 3 of SHIFT -> next cycle IDLE, out_valid=0, sum=0.
//     A new op then completes correctly.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Bit-counter width; it only has to reach WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_adder_fa_cell.sv
// Single combinational full-adder cell driven by serial_adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input logic           clk,
    input logic           rst_n,
    serial_adder_if.slave bus
);
    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif
    logic             fa_sum, fa_carry;

    fa_cell u_fa_cell (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .c    (carry_q),
        .sum  (fa_sum),
        .carry(fa_carry)
    );

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path through the case infers a latch.
        state_d     = state_q;
        a_sr_d      = a_sr_q;
        b_sr_d      = b_sr_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_sr_d     = bus.a;
                    b_sr_d     = bus.b;
                    carry_d    = bus.cin;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                carry_d = fa_carry;
                if (cnt_q == CNT_LAST) begin
                    // Counter holds at WIDTH-1; it is reloaded on the next accept.
                    cout_d      = fa_carry;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q here is the carry into the MSB.
                    ovf_d       = carry_q ^ fa_carry;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // NOTE: reset is synchronous, so it is tested inside the clocked block, not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule
